// File: rtl/chaser_pkg.sv
// Shared types and default sizes for the multi-mode LED chaser.
package chaser_pkg;

   typedef enum logic [1:0] {
      SINGLE   = 2'd0,
      PINGPONG = 2'd1,
      BAR      = 2'd2,
      JOHNSON  = 2'd3
   } chaser_mode_e;

   localparam int unsigned DefNbits = 8;
   localparam int unsigned DefDivW  = 26;

endpackage

// File: rtl/led_chaser_multi_if.sv
// Control and LED bundle for led_chaser_multi; master drives controls, slave is the chaser.
interface led_chaser_multi_if
   import chaser_pkg::*;
#(
   parameter int unsigned NBITS = DefNbits,
   parameter int unsigned DIV_W = DefDivW
);
   logic             restart;
   logic             freeze;
   logic             dir;
   logic [1:0]       mode;
   logic [DIV_W-1:0] step_div;
   logic [3:0]       brightness;
   logic [NBITS-1:0] led;
   logic             step_pulse;
   logic             sweep_done;

   modport master (
      output restart, freeze, dir, mode, step_div, brightness,
      input  led, step_pulse, sweep_done
   );

   modport slave (
      input  restart, freeze, dir, mode, step_div, brightness,
      output led, step_pulse, sweep_done
   );
endinterface

// File: rtl/chaser_prescaler.sv
// Step-rate divider: strobes once every step_div+1 unfrozen clocks, restarted by clear.
module chaser_prescaler
   import chaser_pkg::*;
#(
   parameter int unsigned DIV_W = DefDivW
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic             freeze,
   input  logic             clear,
   input  logic [DIV_W-1:0] step_div,
   output logic             step
);

   logic [DIV_W-1:0] cnt_q;

   assign step = !clear && !freeze && (cnt_q == step_div);

   // A step_div lowered below cnt_q lets the counter run on and wrap.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (!freeze) begin
         cnt_q <= (cnt_q == step_div) ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/led_chaser_multi.sv
// Four-pattern LED chaser (single, ping-pong, bar, Johnson) with freeze/restart/direction.
// Optional brightness PWM on the LED output when CHASER_PWM_EN is defined.
module led_chaser_multi
   import chaser_pkg::*;
#(
   parameter int unsigned NBITS = DefNbits,
   parameter int unsigned DIV_W = DefDivW
) (
   input  logic              clk_2,
   input  logic              reset,
   led_chaser_multi_if.slave bus
);

   localparam logic [NBITS-1:0] MsbHot  = {1'b1, {(NBITS-1){1'b0}}};
   localparam logic [NBITS-1:0] LsbHot  = {{(NBITS-1){1'b0}}, 1'b1};
   localparam logic [NBITS-1:0] AllOnes = {NBITS{1'b1}};

   chaser_mode_e     mode_e;
   logic [1:0]       mode_q;
   logic             dir_q;
   logic [NBITS-1:0] pat_q;
   logic [NBITS-1:0] pat_step;
   logic [NBITS-1:0] start_pat;
   logic             bounce_q;     // 0 = moving right, 1 = moving left
   logic             bounce_step;
   logic             sweep_step;
   logic             step_pulse_q;
   logic             sweep_done_q;
   logic             reload;
   logic             step;

   assign mode_e = chaser_mode_e'(bus.mode);

   assign reload = bus.restart || (bus.mode != mode_q) ||
                   ((bus.dir != dir_q) && (mode_e != PINGPONG));

   chaser_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk_2    (clk_2),
      .reset    (reset),
      .freeze   (bus.freeze),
      .clear    (reload),
      .step_div (bus.step_div),
      .step     (step)
   );

   always_comb begin
      start_pat = bus.dir ? LsbHot : MsbHot;
      if (mode_e == JOHNSON) begin
         start_pat = '0;
      end
   end

   always_comb begin
      pat_step    = pat_q;
      bounce_step = bounce_q;
      sweep_step  = 1'b0;
      case (mode_e)
         SINGLE: begin
            if (pat_q == '0) begin
               pat_step = start_pat;
            end else if (!bus.dir) begin
               if (pat_q[0]) begin
                  pat_step   = MsbHot;
                  sweep_step = 1'b1;
               end else begin
                  pat_step = pat_q >> 1;
               end
            end else begin
               if (pat_q[NBITS-1]) begin
                  pat_step   = LsbHot;
                  sweep_step = 1'b1;
               end else begin
                  pat_step = pat_q << 1;
               end
            end
         end
         PINGPONG: begin
            if (pat_q == '0) begin
               pat_step    = start_pat;
               bounce_step = bus.dir;
            end else if (!bounce_q) begin
               pat_step = pat_q >> 1;
               if (pat_step[0]) begin
                  bounce_step = 1'b1;
                  sweep_step  = 1'b1;
               end
            end else begin
               pat_step = pat_q << 1;
               if (pat_step[NBITS-1]) begin
                  bounce_step = 1'b0;
                  sweep_step  = 1'b1;
               end
            end
         end
         BAR: begin
            if (pat_q == AllOnes) begin
               pat_step   = '0;
               sweep_step = 1'b1;
            end else if (pat_q == '0) begin
               pat_step = start_pat;
            end else if (!bus.dir) begin
               pat_step = {1'b1, pat_q[NBITS-1:1]};
            end else begin
               pat_step = {pat_q[NBITS-2:0], 1'b1};
            end
         end
         JOHNSON: begin
            if (!bus.dir) begin
               pat_step = {~pat_q[0], pat_q[NBITS-1:1]};
            end else begin
               pat_step = {pat_q[NBITS-2:0], ~pat_q[NBITS-1]};
            end
            sweep_step = (pat_step == '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         pat_q        <= MsbHot;
         bounce_q     <= 1'b0;
         mode_q       <= 2'd0;
         dir_q        <= 1'b0;
         step_pulse_q <= 1'b0;
         sweep_done_q <= 1'b0;
      end else begin
         mode_q       <= bus.mode;
         dir_q        <= bus.dir;
         step_pulse_q <= 1'b0;
         sweep_done_q <= 1'b0;
         if (reload) begin
            pat_q <= start_pat;
            if (mode_e == PINGPONG) begin
               bounce_q <= bus.dir;
            end
         end else if (step) begin
            pat_q        <= pat_step;
            bounce_q     <= bounce_step;
            step_pulse_q <= 1'b1;
            sweep_done_q <= sweep_step;
         end
      end
   end

   assign bus.step_pulse = step_pulse_q;
   assign bus.sweep_done = sweep_done_q;

`ifdef CHASER_PWM_EN
   logic [3:0] pwm_cnt_q;

   always_ff @(posedge clk_2) begin
      if (reset) begin
         pwm_cnt_q <= 4'd0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 4'd1;
      end
   end

   assign bus.led = pat_q & {NBITS{pwm_cnt_q < bus.brightness}};
`else
   logic unused_brightness;
   assign unused_brightness = ^bus.brightness;
   assign bus.led           = pat_q;
`endif

endmodule

// File: tb/tb_led_chaser_multi.sv
// Directed self-checking bench for led_chaser_multi (NBITS=8); honours CHASER_PWM_EN.
module tb_led_chaser_multi;

   logic clk_2 = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk_2 = ~clk_2;

   led_chaser_multi_if #(.NBITS(8), .DIV_W(26)) bus ();

   led_chaser_multi #(
      .NBITS (8),
      .DIV_W (26)
   ) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus)
   );

`ifdef CHASER_PWM_EN
   logic [3:0] pwm_m;
   always @(posedge clk_2) begin
      if (reset) pwm_m <= 4'd0;
      else       pwm_m <= pwm_m + 4'd1;
   end
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] masked(input logic [7:0] pat);
`ifdef CHASER_PWM_EN
      return (pwm_m < bus.brightness) ? pat : 8'h00;
`else
      return pat;
`endif
   endfunction

   task automatic tick();
      @(posedge clk_2);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] pat, input logic p,
                             input logic s);
      check_eq({tag, ".led"}, {24'd0, bus.led}, {24'd0, masked(pat)});
      check_eq({tag, ".pulse"}, {31'd0, bus.step_pulse}, {31'd0, p});
      check_eq({tag, ".sweep"}, {31'd0, bus.sweep_done}, {31'd0, s});
   endtask

   logic [7:0] ff;
   logic [7:0] prev;
   logic [7:0] e;
   int         on_cnt;

   initial begin
      ff             = 8'hFF;
      reset          = 1'b1;
      bus.restart    = 1'b0;
      bus.freeze     = 1'b0;
      bus.dir        = 1'b0;
      bus.mode       = 2'd0;
      bus.step_div   = 26'd0;
`ifdef CHASER_PWM_EN
      bus.brightness = 4'd9;
`else
      bus.brightness = 4'd0;
`endif
      tick();
      tick();
      expect_out("rst", 8'h80, 1'b0, 1'b0);

      // Single dot, rightward, one step per clock
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         e = (i < 7) ? (8'h40 >> i) : 8'h80;
         expect_out("single_r", e, 1'b1, i == 7);
      end

      // Ping-pong at one step per 4 clocks; dir toggle mid-run must not reload
      bus.mode     = 2'd1;
      bus.step_div = 26'd3;
      tick();
      expect_out("pp_reload", 8'h80, 1'b0, 1'b0);
      prev = 8'h80;
      for (int i = 0; i < 14; i++) begin
         if (i == 2) bus.dir = 1'b1;
         e = (i <= 6) ? (8'h40 >> i) : (8'h01 << (i - 6));
         repeat (3) begin
            tick();
            expect_out("pp_hold", prev, 1'b0, 1'b0);
         end
         tick();
         expect_out("pp_step", e, 1'b1, (i == 6) || (i == 13));
         prev = e;
      end

      // Bar fill leftward with a 10-clock freeze in the middle
      bus.mode     = 2'd2;
      bus.step_div = 26'd0;
      tick();
      expect_out("bar_reload", 8'h01, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         if (k == 3) begin
            bus.freeze = 1'b1;
            repeat (10) begin
               tick();
               expect_out("bar_freeze", 8'h0F, 1'b0, 1'b0);
            end
            bus.freeze = 1'b0;
         end
         tick();
         if (k <= 6)      e = 8'((32'd1 << (k + 2)) - 32'd1);
         else if (k == 7) e = 8'h00;
         else             e = 8'h01;
         expect_out("bar_step", e, 1'b1, k == 7);
      end

      // Johnson ring rightward, then mode switch mid-run reloads silently
      bus.mode = 2'd3;
      bus.dir  = 1'b0;
      tick();
      expect_out("jn_reload", 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 19; k++) begin
         int j;
         j = k % 16;
         e = (j < 8) ? (ff << (7 - j)) : (ff >> (j - 7));
         tick();
         expect_out("jn_step", e, 1'b1, k == 15);
      end
      bus.mode = 2'd0;
      tick();
      expect_out("jn_to_single", 8'h80, 1'b0, 1'b0);

      // Reset mid ping-pong sweep (bounce left); reset beats restart
      bus.mode = 2'd1;
      bus.dir  = 1'b1;
      tick();
      expect_out("pp2_reload", 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("pp2_step", 8'h02 << i, 1'b1, 1'b0);
      end
      reset = 1'b1;
      tick();
      expect_out("rst_mid", 8'h80, 1'b0, 1'b0);
      bus.restart = 1'b1;
      tick();
      expect_out("rst_vs_restart", 8'h80, 1'b0, 1'b0);
      reset       = 1'b0;
      bus.restart = 1'b0;
      tick();
      expect_out("post_rst_reload", 8'h01, 1'b0, 1'b0);
      tick();
      expect_out("post_rst_step", 8'h02, 1'b1, 1'b0);
      bus.restart = 1'b1;
      tick();
      expect_out("restart", 8'h01, 1'b0, 1'b0);
      bus.restart = 1'b0;

      // Single dot leftward with wrap to LSB
      bus.mode = 2'd0;
      tick();
      expect_out("single_l_reload", 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         e = (i < 7) ? (8'h02 << i) : 8'h01;
         expect_out("single_l", e, 1'b1, i == 7);
      end

      // Frozen pattern: count how many clocks the LEDs are lit
      bus.freeze = 1'b1;
`ifdef CHASER_PWM_EN
      bus.brightness = 4'd4;
`else
      bus.brightness = 4'd0;
`endif
      on_cnt = 0;
      repeat (16) begin
         tick();
         expect_out("frz_pwm", 8'h01, 1'b0, 1'b0);
         if (bus.led == 8'h01) on_cnt++;
      end
`ifdef CHASER_PWM_EN
      check_eq("pwm_on_count", on_cnt, 32'd4);
`else
      check_eq("led_on_count", on_cnt, 32'd16);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
